ofifo_deskew: RTL and testbench

Output-side buffer for the PE array: the counterpart of the row-staggered L0 input buffer. Each array column delivers partial sums on its own skewed cycle, so this block buffers every column independently. It presents a column-aligned vector only once every column holds data, and the vector is drained by the core controller toward SRAM writeback.

---
 rtl/ofifo_deskew_pkg.sv | 13 +
 rtl/ofifo_col_fifo.sv | 52 +++++
 rtl/ofifo_deskew.sv | 64 ++++++
 tb/tb_ofifo_deskew.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ofifo_deskew_pkg.sv
// Shared constants and helpers for the output-side deskew FIFO.
package ofifo_deskew_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  // Pointer width: one extra MSB beyond the index distinguishes full from empty.
  function automatic int ofifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column first-word-fall-through FIFO with wrap-bit pointers.
module ofifo_col_fifo
  import ofifo_deskew_pkg::*;
#(
  parameter int bw    = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] in,
  output logic [bw-1:0] out,
  output logic          o_empty,
  output logic          o_full
);

  localparam int PW = ofifo_ptr_w(depth);
  localparam int AW = PW - 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [bw-1:0] r_mem [depth];
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // A full column drops the write even if a pop happens in the same cycle.
  assign w_push = wr & ~o_full;
  assign w_pop  = rd & ~o_empty;

  // Pointer state; reset empties the column without touching storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage write; entries need no reset since the top masks out while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in;
  end

  assign out = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ofifo_deskew.sv
// Per-column buffering of skewed PE-array partial sums into aligned vectors.
module ofifo_deskew
  import ofifo_deskew_pkg::*;
#(
  parameter int col   = COL,
  parameter int bw    = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_overflow
);

  logic [col-1:0]    w_empty;
  logic [col-1:0]    w_full;
  logic [col-1:0]    w_ovf_col;
  logic [col*bw-1:0] w_head;
  logic              w_pop;
  logic              r_overflow;

  // A pop only counts when every column has a head entry; all columns move together.
  assign w_pop = rd & o_valid;

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_col
      assign w_ovf_col[gi] = wr[gi] & w_full[gi];

      ofifo_col_fifo #(
        .bw    (bw),
        .depth (depth)
      ) u_col (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr[gi] & ~w_full[gi]),
        .rd      (w_pop),
        .in      (in[bw*gi +: bw]),
        .out     (w_head[bw*gi +: bw]),
        .o_empty (w_empty[gi]),
        .o_full  (w_full[gi])
      );
    end
  endgenerate

  assign o_valid    = ~|w_empty;
  assign o_full     = |w_full;
  assign o_ready    = ~o_full;
  assign out        = o_valid ? w_head : '0;
  assign o_overflow = r_overflow;

  // Sticky overflow flag: any write attempt into a full column, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) r_overflow <= 1'b0;
    else if (|w_ovf_col) r_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_ofifo_deskew.sv
// Directed self-checking bench for ofifo_deskew.
module tb_ofifo_deskew;

  localparam int COLS = 8;
  localparam int BW   = 16;
  localparam int W    = COLS * BW;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic [7:0]   wr;
  logic         rd;
  logic [W-1:0] out;
  logic         o_valid, o_full, o_ready, o_overflow;

  int n_vec  = 0;
  int n_miss = 0;

  ofifo_deskew #(.col(COLS), .bw(BW), .depth(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    logic [W-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*BW +: BW] = v;
    return r;
  endfunction

  // Per-column distinct pattern: column c holds base + c*0x1000.
  function automatic logic [W-1:0] mkv(input logic [15:0] base);
    logic [W-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*BW +: BW] = base + 16'(c * 16'h1000);
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic skew_fill(input string tag);
    logic [W-1:0] expv;
    for (int i = 0; i < COLS; i++) begin
      in = '0;
      in[i*BW +: BW] = 16'(16'h0100 * i + 1);
      expv[i*BW +: BW] = 16'(16'h0100 * i + 1);
      wr = 8'(1 << i);
      tick();
      check($sformatf("%s_valid_%0d", tag, i), W'(o_valid), W'(i == COLS - 1));
    end
    wr = '0;
    check({tag, "_out"}, out, expv);
    rd = 1'b1; tick(); rd = 1'b0;
    check({tag, "_pop_valid"}, W'(o_valid), W'(0));
    check({tag, "_pop_out"}, out, W'(0));
  endtask

  task automatic write_vec(input logic [W-1:0] v);
    in = v; wr = 8'hFF; tick(); wr = '0;
  endtask

  initial begin
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;

    // Reset then idle
    do_reset();
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_full", W'(o_full), W'(0));
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_ovf", W'(o_overflow), W'(0));
    check("rst_out", out, W'(0));
    rd = 1'b1; tick(); tick(); rd = 1'b0;
    check("idle_rd_valid", W'(o_valid), W'(0));
    check("idle_rd_ovf", W'(o_overflow), W'(0));

    // Skewed fill
    skew_fill("skew");

    // Depth and overflow
    for (int k = 0; k < 64; k++) begin
      write_vec(rep(16'(k)));
      if (k == 62) check("fill_notfull_63", W'(o_full), W'(0));
    end
    check("fill_full", W'(o_full), W'(1));
    check("fill_ready", W'(o_ready), W'(0));
    check("fill_ovf_pre", W'(o_overflow), W'(0));
    write_vec(rep(16'hBEEF));
    check("ovf_set", W'(o_overflow), W'(1));
    check("ovf_head", out, rep(16'h0000));
    for (int k = 0; k < 64; k++) begin
      check($sformatf("drain_%0d", k), out, rep(16'(k)));
      rd = 1'b1; tick(); rd = 1'b0;
    end
    check("drain_empty", W'(o_valid), W'(0));
    check("ovf_sticky", W'(o_overflow), W'(1));

    // Full with simultaneous rd and wr
    do_reset();
    check("rst2_ovf", W'(o_overflow), W'(0));
    for (int k = 0; k < 64; k++) write_vec(rep(16'(k)));
    in = rep(16'hAAAA); wr = 8'hFF; rd = 1'b1; tick(); wr = '0; rd = 1'b0;
    check("fullrw_ovf", W'(o_overflow), W'(1));
    check("fullrw_full", W'(o_full), W'(0));
    check("fullrw_head", out, rep(16'd1));
    for (int k = 1; k < 64; k++) begin
      if (k == 63) check("fullrw_last", out, rep(16'd63));
      rd = 1'b1; tick(); rd = 1'b0;
    end
    check("fullrw_63_entries", W'(o_valid), W'(0));

    // Occupancy 10 with simultaneous rd and wr
    do_reset();
    for (int k = 0; k < 10; k++) write_vec(mkv(16'(100 + k)));
    in = mkv(16'd200); wr = 8'hFF; rd = 1'b1; tick(); wr = '0; rd = 1'b0;
    check("occ10_ovf", W'(o_overflow), W'(0));
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("occ10_pop_%0d", k), out, (k == 10) ? mkv(16'd200) : mkv(16'(100 + k)));
      rd = 1'b1; tick(); rd = 1'b0;
    end
    check("occ10_empty", W'(o_valid), W'(0));

    // Wrap-around
    do_reset();
    for (int j = 0; j < 200; j++) begin
      write_vec(mkv(16'(j * 3)));
      if (o_full !== 1'b0) check($sformatf("wrap_full_%0d", j), W'(o_full), W'(0));
      check($sformatf("wrap_%0d", j), out, mkv(16'(j * 3)));
      rd = 1'b1; tick(); rd = 1'b0;
    end
    check("wrap_empty", W'(o_valid), W'(0));
    check("wrap_ovf", W'(o_overflow), W'(0));

    // Reset mid-operation
    for (int k = 0; k < 5; k++) write_vec(mkv(16'(k + 1)));
    check("mid_valid_pre", W'(o_valid), W'(1));
    reset = 1'b1; rd = 1'b1; wr = 8'hFF; in = rep(16'h5555); tick();
    reset = 1'b0; rd = 1'b0; wr = '0;
    check("mid_valid", W'(o_valid), W'(0));
    check("mid_out", out, W'(0));
    check("mid_full", W'(o_full), W'(0));
    skew_fill("skew2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
